// File: rtl/register_file_pkg.sv
// Shared datapath constants: register-file geometry, the x0 index and the
// ALUControl encodings used by the ALU and the main decoder.
package register_file_pkg;

  localparam int DATA_WIDTH     = 64;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int REG_ZERO       = 0;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_AND = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_XOR = 4'b0100,
    ALU_SLL = 4'b0101,
    ALU_SRL = 4'b0110
  } alu_ctrl_e;

endpackage

// File: rtl/register_file_if.sv
// Register-file port bundle: two operand read ports, one write-back port and
// a debug read port.
interface register_file_if #(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH
);

  // No handshake: reads are combinational from the addresses, and a write is
  // taken on every rising edge where RegWrite is high (no valid/ready pair).
  logic [ADDR_WIDTH-1:0] ReadReg1;
  logic [ADDR_WIDTH-1:0] ReadReg2;
  logic [ADDR_WIDTH-1:0] WriteReg;
  logic [DATA_WIDTH-1:0] WriteData;
  logic                  RegWrite;
  logic [DATA_WIDTH-1:0] ReadData1;
  logic [DATA_WIDTH-1:0] ReadData2;
  logic [ADDR_WIDTH-1:0] DbgReg;
  logic [DATA_WIDTH-1:0] DbgData;

  modport master (
    output ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
    input  ReadData1, ReadData2, DbgData
  );

  modport slave (
    input  ReadReg1, ReadReg2, WriteReg, WriteData, RegWrite, DbgReg,
    output ReadData1, ReadData2, DbgData
  );

endinterface

// File: rtl/regfile_read_port.sv
// One operand read port: x0 forcing plus optional same-cycle write bypass.
module regfile_read_port #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int BYPASS     = 1
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] array_data,
  input  logic                  bypass_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] data
);
  import register_file_pkg::*;

  always_comb begin
    data = array_data;
    if ((BYPASS != 0) && bypass_en && (wr_addr != ADDR_WIDTH'(REG_ZERO)) &&
        (addr == wr_addr)) begin
      data = wr_data;
    end
    // x0 wins over everything, including a bypassed write.
    if (addr == ADDR_WIDTH'(REG_ZERO)) begin
      data = '0;
    end
  end

endmodule

// File: rtl/register_file.sv
// 32 x 64 general-purpose register file with hardwired x0, optional
// write-through bypass on the operand ports and an unbypassed debug port.
module register_file #(
  parameter int DATA_WIDTH = register_file_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH = register_file_pkg::REG_ADDR_WIDTH,
  parameter int BYPASS     = 1
) (
  input logic            clk,
  input logic            rst,
  register_file_if.slave rf
);
  import register_file_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  armed_q;
  logic                  wr_fire;
  logic                  bypass_en;

  // armed_q keeps the edge on which reset is released quiet, so a write
  // presented across the release lands one edge later.
  assign wr_fire   = armed_q && (rf.RegWrite == 1'b1) &&
                     (rf.WriteReg != ADDR_WIDTH'(REG_ZERO));
  assign bypass_en = (rf.RegWrite == 1'b1) && !rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      armed_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      armed_q <= 1'b1;
      if (wr_fire) begin
        regs[rf.WriteReg] <= rf.WriteData;
      end
    end
  end

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_rd1 (
    .addr       (rf.ReadReg1),
    .array_data (regs[rf.ReadReg1]),
    .bypass_en  (bypass_en),
    .wr_addr    (rf.WriteReg),
    .wr_data    (rf.WriteData),
    .data       (rf.ReadData1)
  );

  regfile_read_port #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BYPASS     (BYPASS)
  ) u_rd2 (
    .addr       (rf.ReadReg2),
    .array_data (regs[rf.ReadReg2]),
    .bypass_en  (bypass_en),
    .wr_addr    (rf.WriteReg),
    .wr_data    (rf.WriteData),
    .data       (rf.ReadData2)
  );

  assign rf.DbgData = (rf.DbgReg == ADDR_WIDTH'(REG_ZERO)) ? '0 : regs[rf.DbgReg];

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: a bypassing and a non-bypassing instance share one
// stimulus stream and are checked against an array model of the register file.
module tb_register_file;
  import register_file_pkg::*;

  localparam int DW = 64;
  localparam int AW = 5;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [AW-1:0] rr1, rr2, wa, dbg;
  logic [DW-1:0] wd;
  logic          we;

  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_b ();
  register_file_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_n ();

  assign bus_b.ReadReg1 = rr1;  assign bus_n.ReadReg1 = rr1;
  assign bus_b.ReadReg2 = rr2;  assign bus_n.ReadReg2 = rr2;
  assign bus_b.WriteReg = wa;   assign bus_n.WriteReg = wa;
  assign bus_b.WriteData = wd;  assign bus_n.WriteData = wd;
  assign bus_b.RegWrite = we;   assign bus_n.RegWrite = we;
  assign bus_b.DbgReg = dbg;    assign bus_n.DbgReg = dbg;

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(1)) dut_b (
    .clk (clk), .rst (rst), .rf (bus_b.slave)
  );
  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BYPASS(0)) dut_n (
    .clk (clk), .rst (rst), .rf (bus_n.slave)
  );

  // reference model
  logic [DW-1:0] model [32];
  bit            armed;
  int            n_tests = 0;
  int            n_fail  = 0;

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a, input bit byp);
    if (a == 0 || rst) return '0;
    if (byp && we && wa != 0 && wa == a) return wd;
    return model[a];
  endfunction

  function automatic logic [DW-1:0] alu_ref(input alu_ctrl_e op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      ALU_ADD: return a + b;
      ALU_SUB: return a - b;
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_XOR: return a ^ b;
      ALU_SLL: return a << b[5:0];
      ALU_SRL: return a >> b[5:0];
      default: return '0;
    endcase
  endfunction

  // driver tasks
  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = '0;
    armed = 1'b0;
  endtask

  // The first edge after reset release never writes; after it writes follow RegWrite.
  task automatic edge_commit();
    if (!rst && armed && we && wa != 0) model[wa] = wd;
    @(posedge clk);
    #1;
    armed = !rst;
  endtask

  task automatic release_reset();
    @(negedge clk);
    #4;
    rst = 1'b0;
    edge_commit();
  endtask

  task automatic test_reset();
    we = 1'b1;
    wa = 5;  wd = {$urandom, $urandom} | 64'h1; edge_commit();
    wa = 31; wd = {$urandom, $urandom} | 64'h1; edge_commit();
    wa = 9;  wd = {$urandom, $urandom} | 64'h1; edge_commit();
    @(negedge clk);
    #1;
    wa = 5; wd = 64'hDEAD_BEEF_0000_0001;
    rst = 1'b1;
    clear_model();
    for (int k = 0; k < 3; k++) begin
      logic [AW-1:0] idx;
      idx = (k == 0) ? 5'd0 : ((k == 1) ? 5'd5 : 5'd31);
      rr1 = idx; rr2 = idx; dbg = idx;
      #1;
      n_tests += 6;
      if (bus_b.ReadData1 !== 64'd0) begin n_fail++; $display("FAIL reset rd1 byp x%0d: got %h exp 0", idx, bus_b.ReadData1); end
      if (bus_b.ReadData2 !== 64'd0) begin n_fail++; $display("FAIL reset rd2 byp x%0d: got %h exp 0", idx, bus_b.ReadData2); end
      if (bus_b.DbgData   !== 64'd0) begin n_fail++; $display("FAIL reset dbg byp x%0d: got %h exp 0", idx, bus_b.DbgData); end
      if (bus_n.ReadData1 !== 64'd0) begin n_fail++; $display("FAIL reset rd1 nob x%0d: got %h exp 0", idx, bus_n.ReadData1); end
      if (bus_n.ReadData2 !== 64'd0) begin n_fail++; $display("FAIL reset rd2 nob x%0d: got %h exp 0", idx, bus_n.ReadData2); end
      if (bus_n.DbgData   !== 64'd0) begin n_fail++; $display("FAIL reset dbg nob x%0d: got %h exp 0", idx, bus_n.DbgData); end
    end
    we = 1'b0;
    release_reset();
  endtask

  task automatic test_write_read();
    logic [DW-1:0] a, b;
    we = 1'b1;
    wa = 5; wd = 64'h0000_0000_0000_000A; edge_commit();
    wa = 6; wd = 64'd5;                   edge_commit();
    we = 1'b0; rr1 = 5; rr2 = 6;
    #1;
    n_tests += 6;
    if (bus_b.ReadData1 !== 64'd10) begin n_fail++; $display("FAIL wr_rd rd1 byp: got %h exp a", bus_b.ReadData1); end
    if (bus_b.ReadData2 !== 64'd5)  begin n_fail++; $display("FAIL wr_rd rd2 byp: got %h exp 5", bus_b.ReadData2); end
    if (bus_n.ReadData1 !== 64'd10) begin n_fail++; $display("FAIL wr_rd rd1 nob: got %h exp a", bus_n.ReadData1); end
    if (bus_n.ReadData2 !== 64'd5)  begin n_fail++; $display("FAIL wr_rd rd2 nob: got %h exp 5", bus_n.ReadData2); end
    a = bus_b.ReadData1; b = bus_b.ReadData2;
    if (alu_ref(ALU_ADD, a, b) !== 64'd15) begin n_fail++; $display("FAIL alu_add: got %0d exp 15", alu_ref(ALU_ADD, a, b)); end
    if (alu_ref(ALU_SUB, a, b) !== 64'd5)  begin n_fail++; $display("FAIL alu_sub: got %0d exp 5", alu_ref(ALU_SUB, a, b)); end
  endtask

  task automatic test_x0();
    we = 1'b1; wa = 0; wd = '1; rr1 = 0; rr2 = 0; dbg = 0;
    #1;
    n_tests += 2;
    if (bus_b.ReadData1 !== 64'd0) begin n_fail++; $display("FAIL x0 bypass rd1: got %h exp 0", bus_b.ReadData1); end
    if (bus_b.ReadData2 !== 64'd0) begin n_fail++; $display("FAIL x0 bypass rd2: got %h exp 0", bus_b.ReadData2); end
    edge_commit();
    we = 1'b0;
    #1;
    n_tests += 3;
    if (bus_b.ReadData1 !== 64'd0) begin n_fail++; $display("FAIL x0 rd1: got %h exp 0", bus_b.ReadData1); end
    if (bus_b.DbgData   !== 64'd0) begin n_fail++; $display("FAIL x0 dbg byp: got %h exp 0", bus_b.DbgData); end
    if (bus_n.DbgData   !== 64'd0) begin n_fail++; $display("FAIL x0 dbg nob: got %h exp 0", bus_n.DbgData); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wa = 7; wd = 64'd3; edge_commit();
    wd = 64'd9; rr1 = 7; rr2 = 7; dbg = 7;
    #1;
    n_tests += 6;
    if (bus_b.ReadData1 !== 64'd9) begin n_fail++; $display("FAIL byp rd1 pre: got %h exp 9", bus_b.ReadData1); end
    if (bus_b.ReadData2 !== 64'd9) begin n_fail++; $display("FAIL byp rd2 pre: got %h exp 9", bus_b.ReadData2); end
    if (bus_n.ReadData1 !== 64'd3) begin n_fail++; $display("FAIL nob rd1 pre: got %h exp 3", bus_n.ReadData1); end
    if (bus_n.ReadData2 !== 64'd3) begin n_fail++; $display("FAIL nob rd2 pre: got %h exp 3", bus_n.ReadData2); end
    if (bus_b.DbgData   !== 64'd3) begin n_fail++; $display("FAIL byp dbg pre: got %h exp 3", bus_b.DbgData); end
    if (bus_n.DbgData   !== 64'd3) begin n_fail++; $display("FAIL nob dbg pre: got %h exp 3", bus_n.DbgData); end
    edge_commit();
    we = 1'b0;
    #1;
    n_tests += 3;
    if (bus_n.ReadData1 !== 64'd9) begin n_fail++; $display("FAIL nob rd1 post: got %h exp 9", bus_n.ReadData1); end
    if (bus_n.ReadData2 !== 64'd9) begin n_fail++; $display("FAIL nob rd2 post: got %h exp 9", bus_n.ReadData2); end
    if (bus_b.DbgData   !== 64'd9) begin n_fail++; $display("FAIL byp dbg post: got %h exp 9", bus_b.DbgData); end
  endtask

  task automatic test_write_disable();
    logic [DW-1:0] v1, v2;
    we = 1'b0; wa = 31; wd = 64'h1234; dbg = 31; rr1 = 31;
    edge_commit();
    n_tests += 3;
    if (bus_b.DbgData   !== 64'd0) begin n_fail++; $display("FAIL wdis dbg byp: got %h exp 0", bus_b.DbgData); end
    if (bus_n.DbgData   !== 64'd0) begin n_fail++; $display("FAIL wdis dbg nob: got %h exp 0", bus_n.DbgData); end
    if (bus_b.ReadData1 !== 64'd0) begin n_fail++; $display("FAIL wdis rd1 byp: got %h exp 0", bus_b.ReadData1); end
    we = 1'b1; edge_commit(); we = 1'b0;
    #1;
    n_tests += 2;
    if (bus_b.DbgData !== 64'h1234) begin n_fail++; $display("FAIL x31 dbg byp: got %h exp 1234", bus_b.DbgData); end
    if (bus_n.DbgData !== 64'h1234) begin n_fail++; $display("FAIL x31 dbg nob: got %h exp 1234", bus_n.DbgData); end
    v2 = {$urandom, $urandom}; v1 = {$urandom, $urandom};
    we = 1'b1;
    wa = 2; wd = v2; edge_commit();
    wa = 1; wd = v1; edge_commit();
    we = 1'b0; rr1 = 0; rr2 = 2; dbg = 1;
    #1;
    n_tests += 4;
    if (bus_b.ReadData1 !== 64'd0) begin n_fail++; $display("FAIL x1wr x0: got %h exp 0", bus_b.ReadData1); end
    if (bus_b.ReadData2 !== v2)    begin n_fail++; $display("FAIL x1wr x2 byp: got %h exp %h", bus_b.ReadData2, v2); end
    if (bus_n.ReadData2 !== v2)    begin n_fail++; $display("FAIL x1wr x2 nob: got %h exp %h", bus_n.ReadData2, v2); end
    if (bus_b.DbgData   !== v1)    begin n_fail++; $display("FAIL x1wr x1: got %h exp %h", bus_b.DbgData, v1); end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    #1;
    rst = 1'b1;
    clear_model();
    we = 1'b1; wa = 4; wd = 64'd8; dbg = 4; rr1 = 4;
    release_reset();
    n_tests += 2;
    if (bus_b.DbgData !== 64'd0) begin n_fail++; $display("FAIL rel quiet byp: got %h exp 0", bus_b.DbgData); end
    if (bus_n.DbgData !== 64'd0) begin n_fail++; $display("FAIL rel quiet nob: got %h exp 0", bus_n.DbgData); end
    edge_commit();
    we = 1'b0;
    #1;
    n_tests += 3;
    if (bus_b.DbgData   !== 64'd8) begin n_fail++; $display("FAIL rel write byp: got %h exp 8", bus_b.DbgData); end
    if (bus_n.DbgData   !== 64'd8) begin n_fail++; $display("FAIL rel write nob: got %h exp 8", bus_n.DbgData); end
    if (bus_n.ReadData1 !== 64'd8) begin n_fail++; $display("FAIL rel rd1 nob: got %h exp 8", bus_n.ReadData1); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 300; it++) begin
      we  = 1'($urandom_range(0, 1));
      wa  = AW'($urandom_range(0, 31));
      wd  = {$urandom, $urandom};
      rr1 = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, 31));
      rr2 = ($urandom_range(0, 2) == 0) ? wa : AW'($urandom_range(0, 31));
      dbg = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, 31));
      #1;
      n_tests += 6;
      if (bus_b.ReadData1 !== exp_rd(rr1, 1)) begin n_fail++; $display("FAIL rand rd1 byp x%0d: got %h exp %h", rr1, bus_b.ReadData1, exp_rd(rr1, 1)); end
      if (bus_b.ReadData2 !== exp_rd(rr2, 1)) begin n_fail++; $display("FAIL rand rd2 byp x%0d: got %h exp %h", rr2, bus_b.ReadData2, exp_rd(rr2, 1)); end
      if (bus_n.ReadData1 !== exp_rd(rr1, 0)) begin n_fail++; $display("FAIL rand rd1 nob x%0d: got %h exp %h", rr1, bus_n.ReadData1, exp_rd(rr1, 0)); end
      if (bus_n.ReadData2 !== exp_rd(rr2, 0)) begin n_fail++; $display("FAIL rand rd2 nob x%0d: got %h exp %h", rr2, bus_n.ReadData2, exp_rd(rr2, 0)); end
      if (bus_b.DbgData   !== exp_rd(dbg, 0)) begin n_fail++; $display("FAIL rand dbg byp x%0d: got %h exp %h", dbg, bus_b.DbgData, exp_rd(dbg, 0)); end
      if (bus_n.DbgData   !== exp_rd(dbg, 0)) begin n_fail++; $display("FAIL rand dbg nob x%0d: got %h exp %h", dbg, bus_n.DbgData, exp_rd(dbg, 0)); end
      edge_commit();
    end
    we = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg = AW'(i);
      #1;
      n_tests += 2;
      if (bus_b.DbgData !== exp_rd(dbg, 0)) begin n_fail++; $display("FAIL sweep byp x%0d: got %h exp %h", i, bus_b.DbgData, exp_rd(dbg, 0)); end
      if (bus_n.DbgData !== exp_rd(dbg, 0)) begin n_fail++; $display("FAIL sweep nob x%0d: got %h exp %h", i, bus_n.DbgData, exp_rd(dbg, 0)); end
    end
  endtask

  initial begin
    rr1 = '0; rr2 = '0; wa = '0; dbg = '0; wd = '0; we = 1'b0;
    clear_model();
    #12;
    release_reset();
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_write_disable();
    test_reset_release();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/register_file.md
Name: register_file

Overview:
- 32-entry x 64-bit general-purpose register file for the single-cycle datapath.
- Sits directly upstream of the ALU: ReadData1 drives ALU operand A, and ReadData2 drives operand B (or the immediate mux).
- The write-back result (ALU Result or load data) returns on the write port.
- Register x0 is hardwired to zero. An optional write-through bypass and a debug read port are provided for the bench.

Parameters:
- DATA_WIDTH, 64, register and data-port width.
- ADDR_WIDTH, 5, register index width; depth is 2**ADDR_WIDTH = 32.
- BYPASS, 1, 1 = a read of the register being written in the same cycle returns WriteData; 0 = it returns the old value.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- ReadReg1  input  ADDR_WIDTH  index for read port 1 (rs1).
- ReadReg2  input  ADDR_WIDTH  index for read port 2 (rs2).
- WriteReg  input  ADDR_WIDTH  destination index (rd).
- WriteData  input  DATA_WIDTH  write-back value.
- RegWrite  input  1  write enable.
- ReadData1  output  DATA_WIDTH  combinational read of ReadReg1 (to ALU A).
- ReadData2  output  DATA_WIDTH  combinational read of ReadReg2 (to ALU B mux).
- DbgReg  input  ADDR_WIDTH  debug read index.
- DbgData  output  DATA_WIDTH  combinational read of DbgReg; no bypass, always array contents.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high on rst.
- rst asserted (asynchronous, no clock needed):
  - All 32 entries clear to 0.
  - ReadData1, ReadData2 and DbgData read 0 for every index.
  - Bypass is suppressed while rst = 1.
- Write:
  - On posedge clk with rst = 0, RegWrite = 1 and WriteReg != 0: entry[WriteReg] <= WriteData.
  - A write to index 0 is silently dropped; entry 0 never changes.
- Read:
  - Purely combinational from the address and array.
  - Index 0 always returns 0, regardless of array or bypass state.
- Bypass (BYPASS = 1):
  - If RegWrite = 1, rst = 0, WriteReg != 0 and ReadRegN == WriteReg, then ReadDataN = WriteData in the same cycle.
  - Each read port is evaluated independently; both ports may bypass at once.
- BYPASS = 0: a same-cycle read returns the pre-edge value. The new value is visible after the edge.
- RegWrite = 0: the array holds and WriteData is ignored.
- rst asserted mid-cycle with a write pending: reset wins and the entry is 0 after reset.
- rst deasserting coincident with posedge clk: no write occurs on that edge. The first write is captured on the next edge.
- Latency: read 0 cycles; write 1 edge.
- X-safety: an X on RegWrite must not corrupt entry 0.

Decomposition:
- Shared package/defines file holds:
  - DATA_WIDTH = 64 and REG_ADDR_WIDTH = 5.
  - REG_ZERO = 0.
  - ALUControl encodings: ADD 0000, SUB 0001, AND 0010, OR 0011, XOR 0100, SLL 0101, SRL 0110.
  - These are shared with the ALU and the main decoder.
- One sub-module is natural: regfile_read_port.
  - Inputs: address, array read value, write-port signals, BYPASS.
  - Applies the x0 forcing and the bypass compare.
  - Instantiated twice for the operand ports. DbgData uses array plus x0 forcing only.

Test Plan:
- Reset: assert rst asynchronously mid-cycle after prior writes -> all three read ports return 0 for indices 0, 5, 31, with no clock edge required.
- Write/read: write x5 = 64'h0000_0000_0000_000A and x6 = 5 on two edges, then read ReadReg1 = 5, ReadReg2 = 6 -> 10 and 5. Feed both to the ALU with ADD (0000) -> 15, and with SUB (0001) -> 5.
- x0: RegWrite = 1, WriteReg = 0, WriteData = 64'hFFFF_FFFF_FFFF_FFFF, clock -> ReadData1 (x0) = 0 and DbgData (x0) = 0.
- Bypass: with x7 = 3, drive RegWrite = 1, WriteReg = 7, WriteData = 9 and ReadReg1 = ReadReg2 = 7 before the edge:
  - BYPASS = 1 -> both ports read 9.
  - BYPASS = 0 -> both read 3, then 9 after the edge.
  - DbgData = 3 before the edge in both cases.
- Write disable and boundary: RegWrite = 0, WriteReg = 31, WriteData = 64'h1234 -> x31 unchanged (0). Then RegWrite = 1 -> x31 = 64'h1234. Separately, a write to x1 does not alter x0 or x2.
- Reset release: deassert rst coincident with a posedge while RegWrite = 1, WriteReg = 4, WriteData = 8 -> x4 = 0 after that edge, and x4 = 8 after the following edge.
